// File: rtl/fifo_ctrl_sync.sv
// Pointer/flag controller for a single-clock FIFO: accepts requests, drives the
// storage write strobe and wrap-bit pointers, and reports occupancy and errors.
module fifo_ctrl_sync #(
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2,
    localparam int A        = $clog2(DEPTH),
    localparam int PW       = A + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_req,
    input  logic          i_rd_req,
    input  logic          i_clr,
    output logic          o_mem_wr_en,
    output logic          o_rd_ack,
    output logic [PW-1:0] o_b_wr_ptr,
    output logic [PW-1:0] o_b_rd_ptr,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_almost_full,
    output logic          o_almost_empty,
    output logic [PW-1:0] o_count,
    output logic          o_overflow,
    output logic          o_underflow
);

    localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          full, empty, wr_acc, rd_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[A] != rd_ptr_q[A]) && (wr_ptr_q[A-1:0] == rd_ptr_q[A-1:0]);

    // Strobes are gated by reset so the array never sees a write while held in reset.
    assign wr_acc = i_rst_n && i_wr_req && !full  && !i_clr;
    assign rd_acc = i_rst_n && i_rd_req && !empty && !i_clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (i_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
            if (i_wr_req && full)  ovf_d = 1'b1;
            if (i_rd_req && empty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign o_mem_wr_en    = wr_acc;
    assign o_rd_ack       = rd_acc;
    assign o_b_wr_ptr     = wr_ptr_q;
    assign o_b_rd_ptr     = rd_ptr_q;
    assign o_full         = full;
    assign o_empty        = empty;
    assign o_count        = count_q;
    assign o_almost_full  = (count_q >= AF_T);
    assign o_almost_empty = (count_q <= AE_T);
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Bench for fifo_ctrl_sync: directed vector table, hand sequences for wrap and
// async reset, then random traffic against an occupancy-based reference model.
module tb_fifo_ctrl_sync;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int PW    = $clog2(DEPTH) + 1;
    localparam int PMOD  = 2 * DEPTH;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_wr_req, i_rd_req, i_clr;
    logic          o_mem_wr_en, o_rd_ack;
    logic [PW-1:0] o_b_wr_ptr, o_b_rd_ptr, o_count;
    logic          o_full, o_empty, o_almost_full, o_almost_empty;
    logic          o_overflow, o_underflow;

    int errors = 0;
    int checks = 0;

    fifo_ctrl_sync #(.DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_req(i_wr_req), .i_rd_req(i_rd_req),
        .i_clr(i_clr), .o_mem_wr_en(o_mem_wr_en), .o_rd_ack(o_rd_ack),
        .o_b_wr_ptr(o_b_wr_ptr), .o_b_rd_ptr(o_b_rd_ptr), .o_full(o_full),
        .o_empty(o_empty), .o_almost_full(o_almost_full),
        .o_almost_empty(o_almost_empty), .o_count(o_count),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic wr, rd, clr;
        logic en, ack;
        int   cnt, wp, rp;
        logic ovf, udf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Registered state and the flags that follow from the expected occupancy.
    task automatic chk_state(input string tag, input int cnt, input int wp, input int rp,
                             input logic ovf, input logic udf);
        chk({tag, " count"}, int'(o_count), cnt);
        chk({tag, " wr_ptr"}, int'(o_b_wr_ptr), wp);
        chk({tag, " rd_ptr"}, int'(o_b_rd_ptr), rp);
        chk({tag, " full"}, int'(o_full), int'(cnt == DEPTH));
        chk({tag, " empty"}, int'(o_empty), int'(cnt == 0));
        chk({tag, " almost_full"}, int'(o_almost_full), int'(cnt >= AF));
        chk({tag, " almost_empty"}, int'(o_almost_empty), int'(cnt <= AE));
        chk({tag, " overflow"}, int'(o_overflow), int'(ovf));
        chk({tag, " underflow"}, int'(o_underflow), int'(udf));
    endtask

    // Inputs are applied just after a rising edge; strobes are sampled on the
    // falling edge and state 1ns after the following rising edge.
    task automatic step(input logic wr, input logic rd, input logic clr,
                        output logic en, output logic ack);
        i_wr_req = wr;
        i_rd_req = rd;
        i_clr    = clr;
        @(negedge i_clk);
        en  = o_mem_wr_en;
        ack = o_rd_ack;
        @(posedge i_clk);
        #1;
    endtask

    function automatic vec_t mk(logic wr, logic rd, logic clr, logic en, logic ack,
                                int cnt, int wp, int rp, logic ovf, logic udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.en = en; v.ack = ack;
        v.cnt = cnt; v.wp = wp; v.rp = rp; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    initial begin
        logic en, ack;
        int   m_cnt, m_wp, m_rp;
        logic m_ovf, m_udf;

        // Fill: 8 writes, then write+read while full, idle, drain, underflow cases, clear.
        for (int i = 0; i < DEPTH; i++) vecs.push_back(mk(1, 0, 0, 1, 0, i + 1, i + 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 7, 8, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 7, 8, 1, 1, 0));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 1, 0, 0, 1, 6 - i, 8, 2 + i, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8, 8, 1, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 1, 9, 8, 1, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 0, 1, 0, 2 + i, 10 + i, 8, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        // Reset state, with a write request held to prove the strobe stays low.
        i_rst_n = 1'b0; i_wr_req = 1'b1; i_rd_req = 1'b1; i_clr = 1'b0;
        #12;
        chk("reset mem_wr_en", int'(o_mem_wr_en), 0);
        chk("reset rd_ack", int'(o_rd_ack), 0);
        chk_state("reset", 0, 0, 0, 0, 0);
        i_wr_req = 1'b0; i_rd_req = 1'b0;
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        foreach (vecs[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            step(vecs[k].wr, vecs[k].rd, vecs[k].clr, en, ack);
            chk({tag, " mem_wr_en"}, int'(en), int'(vecs[k].en));
            chk({tag, " rd_ack"}, int'(ack), int'(vecs[k].ack));
            chk_state(tag, vecs[k].cnt, vecs[k].wp, vecs[k].rp, vecs[k].ovf, vecs[k].udf);
        end

        // Wrap: 12 writes and 12 reads interleaved from empty, occupancy stays <= 1.
        step(0, 0, 1, en, ack);
        step(1, 0, 0, en, ack);
        for (int i = 0; i < 11; i++) begin
            step(1, 1, 0, en, ack);
            chk("wrap both accepted", int'({en, ack}), 3);
            chk("wrap count==wp-rp", int'(o_count), (int'(o_b_wr_ptr) - int'(o_b_rd_ptr) + PMOD) % PMOD);
        end
        step(0, 1, 0, en, ack);
        chk_state("wrap end", 0, 12, 12, 0, 0);

        // Asynchronous reset between edges while holding four entries.
        for (int i = 0; i < 4; i++) step(1, 0, 0, en, ack);
        chk("pre-reset count", int'(o_count), 4);
        i_wr_req = 1'b1;
        @(negedge i_clk); #2;
        i_rst_n = 1'b0;
        #1;
        chk("async reset mem_wr_en", int'(o_mem_wr_en), 0);
        chk_state("async reset", 0, 0, 0, 0, 0);
        i_wr_req = 1'b0;
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Random traffic against an occupancy/pointer model.
        m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
        for (int n = 0; n < 3000; n++) begin
            logic wr, rd, clr, e_en, e_ack;
            int bias;
            bias = (n / 200) % 3;
            wr  = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
            rd  = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
            clr = ($urandom_range(0, 39) == 0);
            e_en  = wr && !clr && (m_cnt != DEPTH);
            e_ack = rd && !clr && (m_cnt != 0);
            step(wr, rd, clr, en, ack);
            if (clr) begin
                m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
            end else begin
                if (wr && m_cnt == DEPTH) m_ovf = 1;
                if (rd && m_cnt == 0) m_udf = 1;
                m_cnt = m_cnt + int'(e_en) - int'(e_ack);
                m_wp  = (m_wp + int'(e_en)) % PMOD;
                m_rp  = (m_rp + int'(e_ack)) % PMOD;
            end
            chk("rand mem_wr_en", int'(en), int'(e_en));
            chk("rand rd_ack", int'(ack), int'(e_ack));
            chk_state("rand", m_cnt, m_wp, m_rp, m_ovf, m_udf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
